// File: rtl/adc_osr_mc_if.sv
// Sample/result bus of the multi-channel ADC oversampler: tagged sample input,
// valid/ready result output, soft restart and sticky overrun status.
interface adc_osr_mc_if #(
  parameter int DATA_W   = 10,
  parameter int OUT_W    = 16,
  parameter int CHANNELS = 4,
  parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
);
  logic [2:0]        osr_mode_in;
  logic              in_valid;
  logic [CH_W-1:0]   in_channel;
  logic [DATA_W-1:0] in_data;
  logic              soft_clr;
  logic              out_valid;
  logic              out_ready;
  logic [CH_W-1:0]   out_channel;
  logic [OUT_W-1:0]  out_data;
  logic              overrun;
  logic              overrun_clr;

  modport master (
    output osr_mode_in, in_valid, in_channel, in_data, soft_clr, out_ready, overrun_clr,
    input  out_valid, out_channel, out_data, overrun
  );

  modport slave (
    input  osr_mode_in, in_valid, in_channel, in_data, soft_clr, out_ready, overrun_clr,
    output out_valid, out_channel, out_data, overrun
  );
endinterface

// File: rtl/adc_osr_mc.sv
// Multi-channel ADC oversampler: sums 4**N samples per channel and emits one
// left-justified DATA_W+N bit result per burst through a single-entry output register.
module adc_osr_mc #(
  parameter int DATA_W   = 10,
  parameter int OUT_W    = 16,
  parameter int CHANNELS = 4,
  parameter int MAX_LOG4 = 4
) (
  input  logic          clk,
  input  logic          rst,
  adc_osr_mc_if.slave   bus
);
  localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int ACC_W = DATA_W + 2 * MAX_LOG4;
  localparam int CNT_W = 2 * MAX_LOG4;

  logic [ACC_W-1:0]  r_acc  [CHANNELS];
  logic [CNT_W-1:0]  r_cnt  [CHANNELS];
  logic [2:0]        r_mode [CHANNELS];
  logic              r_out_valid;
  logic [CH_W-1:0]   r_out_channel;
  logic [OUT_W-1:0]  r_out_data;
  logic              r_overrun;

  logic              w_accept;
  logic              w_first;
  logic [2:0]        w_eff_mode;
  logic [2:0]        w_mode;
  logic [CNT_W-1:0]  w_cur_cnt;
  logic [ACC_W-1:0]  w_sum;
  logic              w_last;
  logic              w_load;
  logic              w_drop;

  function automatic logic [CNT_W-1:0] last_cnt(input logic [2:0] m);
    logic [CNT_W:0] t;
    t = ({{CNT_W{1'b0}}, 1'b1} << {m, 1'b0}) - {{CNT_W{1'b0}}, 1'b1};
    return t[CNT_W-1:0];
  endfunction

  // Truncate the sum by N bits and park the DATA_W+N bit result at the MSBs.
  function automatic logic [OUT_W-1:0] justify(input logic [ACC_W-1:0] s, input logic [2:0] m);
    logic [ACC_W-1:0] q;
    logic [OUT_W-1:0] r;
    q = s >> m;
    r = OUT_W'(q);
    return r << (int'(OUT_W - DATA_W) - int'(m));
  endfunction

  // Decode the addressed channel's next accumulator/counter state and the completion.
  always_comb begin
    w_accept   = 1'b0;
    w_first    = 1'b0;
    w_eff_mode = 3'd0;
    w_mode     = 3'd0;
    w_cur_cnt  = {CNT_W{1'b0}};
    w_sum      = {ACC_W{1'b0}};
    w_last     = 1'b0;
    if (bus.in_valid && (int'(bus.in_channel) < CHANNELS)) begin
      w_accept = 1'b1;
      w_first  = bus.soft_clr || (r_cnt[bus.in_channel] == {CNT_W{1'b0}});
      if (int'(bus.osr_mode_in) <= MAX_LOG4) begin
        w_eff_mode = bus.osr_mode_in;
      end else begin
        w_eff_mode = 3'd0;
      end
      if (w_first) begin
        w_mode    = w_eff_mode;
        w_cur_cnt = {CNT_W{1'b0}};
        w_sum     = ACC_W'(bus.in_data);
      end else begin
        w_mode    = r_mode[bus.in_channel];
        w_cur_cnt = r_cnt[bus.in_channel];
        w_sum     = r_acc[bus.in_channel] + ACC_W'(bus.in_data);
      end
      w_last = (w_cur_cnt == last_cnt(w_mode));
    end else begin
      w_accept = 1'b0;
    end
    w_load = w_accept && w_last && (!r_out_valid || bus.out_ready);
    w_drop = w_accept && w_last && r_out_valid && !bus.out_ready;
  end

  // Per-channel accumulators, sample counters and latched burst modes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < CHANNELS; c++) begin
        r_acc[c]  <= {ACC_W{1'b0}};
        r_cnt[c]  <= {CNT_W{1'b0}};
        r_mode[c] <= 3'd0;
      end
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (bus.soft_clr) begin
          r_acc[c] <= {ACC_W{1'b0}};
          r_cnt[c] <= {CNT_W{1'b0}};
        end
        if (w_accept && (int'(bus.in_channel) == c)) begin
          r_acc[c] <= w_sum;
          r_cnt[c] <= w_last ? {CNT_W{1'b0}} : (w_cur_cnt + {{(CNT_W-1){1'b0}}, 1'b1});
          if (w_first) begin
            r_mode[c] <= w_eff_mode;
          end
        end
      end
    end
  end

  // Single-entry result register with pop-and-load, plus sticky overrun.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid   <= 1'b0;
      r_out_channel <= {CH_W{1'b0}};
      r_out_data    <= {OUT_W{1'b0}};
      r_overrun     <= 1'b0;
    end else begin
      if (w_load) begin
        r_out_valid   <= 1'b1;
        r_out_channel <= bus.in_channel;
        r_out_data    <= justify(w_sum, w_mode);
      end else if (r_out_valid && bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (w_drop) begin
        r_overrun <= 1'b1;
      end else if (bus.overrun_clr) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign bus.out_valid   = r_out_valid;
  assign bus.out_channel = r_out_channel;
  assign bus.out_data    = r_out_data;
  assign bus.overrun     = r_overrun;
endmodule

// File: tb/tb_adc_osr_mc.sv
// Directed bench for adc_osr_mc: a table of single-cycle vectors plus hand
// sequences for interleaved bursts, a 256-sample burst and stale-sum restarts.
module tb_adc_osr_mc;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  adc_osr_mc_if #(.DATA_W(10), .OUT_W(16), .CHANNELS(4)) bus ();

  adc_osr_mc #(.DATA_W(10), .OUT_W(16), .CHANNELS(4), .MAX_LOG4(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic        v;
    logic [1:0]  ch;
    logic [9:0]  d;
    logic [2:0]  m;
    logic        rdy;
    logic        oclr;
    logic        e_v;
    logic [1:0]  e_ch;
    logic [15:0] e_d;
    logic        chk_d;
    logic        e_ovr;
  } vec_t;

  vec_t tbl [18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step(input logic v, input logic [1:0] ch, input logic [9:0] d,
                      input logic [2:0] m, input logic rdy, input logic sclr, input logic oclr);
    bus.in_valid    = v;
    bus.in_channel  = ch;
    bus.in_data     = d;
    bus.osr_mode_in = m;
    bus.out_ready   = rdy;
    bus.soft_clr    = sclr;
    bus.overrun_clr = oclr;
    @(posedge clk);
    #1;
  endtask

  task automatic check_result(input string name, input logic [1:0] ch, input logic [15:0] d);
    check({name, "_valid"}, 32'(bus.out_valid), 32'd1);
    check({name, "_ch"}, 32'(bus.out_channel), 32'(ch));
    check({name, "_data"}, 32'(bus.out_data), 32'(d));
  endtask

  task automatic check_reset_state(input string name);
    check({name, "_valid"}, 32'(bus.out_valid), 32'd0);
    check({name, "_data"}, 32'(bus.out_data), 32'd0);
    check({name, "_ch"}, 32'(bus.out_channel), 32'd0);
    check({name, "_ovr"}, 32'(bus.overrun), 32'd0);
  endtask

  initial begin
    //            v     ch     d        m     rdy   oclr  e_v   e_ch   e_d         chk   e_ovr
    tbl[0]  = '{1'b1, 2'd2, 10'h3FF, 3'd0, 1'b1, 1'b0, 1'b1, 2'd2, 16'hFFC0, 1'b1, 1'b0};
    tbl[1]  = '{1'b0, 2'd0, 10'h000, 3'd0, 1'b1, 1'b0, 1'b0, 2'd0, 16'h0000, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 2'd0, 10'h200, 3'd1, 1'b1, 1'b0, 1'b0, 2'd0, 16'h0000, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 2'd0, 10'h201, 3'd1, 1'b1, 1'b0, 1'b0, 2'd0, 16'h0000, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 2'd0, 10'h202, 3'd1, 1'b1, 1'b0, 1'b0, 2'd0, 16'h0000, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 2'd0, 10'h203, 3'd1, 1'b1, 1'b0, 1'b1, 2'd0, 16'h8060, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 2'd0, 10'h000, 3'd0, 1'b0, 1'b0, 1'b1, 2'd0, 16'h8060, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 2'd0, 10'h000, 3'd0, 1'b1, 1'b0, 1'b0, 2'd0, 16'h0000, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 2'd3, 10'h001, 3'd7, 1'b1, 1'b0, 1'b1, 2'd3, 16'h0040, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 2'd0, 10'h000, 3'd0, 1'b1, 1'b0, 1'b0, 2'd0, 16'h0000, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 2'd0, 10'h001, 3'd0, 1'b0, 1'b0, 1'b1, 2'd0, 16'h0040, 1'b1, 1'b0};
    tbl[11] = '{1'b1, 2'd1, 10'h002, 3'd0, 1'b0, 1'b0, 1'b1, 2'd0, 16'h0040, 1'b1, 1'b1};
    tbl[12] = '{1'b0, 2'd0, 10'h000, 3'd0, 1'b0, 1'b1, 1'b1, 2'd0, 16'h0040, 1'b1, 1'b0};
    tbl[13] = '{1'b1, 2'd1, 10'h002, 3'd0, 1'b0, 1'b1, 1'b1, 2'd0, 16'h0040, 1'b1, 1'b1};
    tbl[14] = '{1'b0, 2'd0, 10'h000, 3'd0, 1'b1, 1'b1, 1'b0, 2'd0, 16'h0000, 1'b0, 1'b0};
    tbl[15] = '{1'b1, 2'd2, 10'h3FF, 3'd0, 1'b1, 1'b0, 1'b1, 2'd2, 16'hFFC0, 1'b1, 1'b0};
    tbl[16] = '{1'b1, 2'd1, 10'h002, 3'd0, 1'b1, 1'b0, 1'b1, 2'd1, 16'h0080, 1'b1, 1'b0};
    tbl[17] = '{1'b0, 2'd0, 10'h000, 3'd0, 1'b1, 1'b0, 1'b0, 2'd0, 16'h0000, 1'b0, 1'b0};

    bus.in_valid = 1'b0; bus.in_channel = 2'd0; bus.in_data = 10'h000; bus.osr_mode_in = 3'd0;
    bus.out_ready = 1'b1; bus.soft_clr = 1'b0; bus.overrun_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("reset");
    rst = 1'b0;
    step(1'b0, 2'd0, 10'h000, 3'd0, 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 18; i++) begin
      step(tbl[i].v, tbl[i].ch, tbl[i].d, tbl[i].m, tbl[i].rdy, 1'b0, tbl[i].oclr);
      check($sformatf("vec%0d_valid", i), 32'(bus.out_valid), 32'(tbl[i].e_v));
      check($sformatf("vec%0d_ovr", i), 32'(bus.overrun), 32'(tbl[i].e_ovr));
      if (tbl[i].chk_d) begin
        check($sformatf("vec%0d_ch", i), 32'(bus.out_channel), 32'(tbl[i].e_ch));
        check($sformatf("vec%0d_data", i), 32'(bus.out_data), 32'(tbl[i].e_d));
      end
    end

    // Mode 2 on ch1/ch3 interleaved: ch1 completes at i=30, ch3 at i=31.
    for (int i = 0; i < 32; i++) begin
      if (i % 2 == 0) step(1'b1, 2'd1, 10'h155, 3'd2, 1'b1, 1'b0, 1'b0);
      else            step(1'b1, 2'd3, 10'h0AA, 3'd2, 1'b1, 1'b0, 1'b0);
      if (i == 30)      check_result("m2_ch1", 2'd1, 16'h5540);
      else if (i == 31) check_result("m2_ch3", 2'd3, 16'h2A80);
      else              check($sformatf("m2_idle%0d", i), 32'(bus.out_valid), 32'd0);
    end

    // Mode 4 on ch0; later samples request mode 1, which must not cut the burst short.
    for (int i = 0; i < 256; i++) begin
      step(1'b1, 2'd0, 10'h3FF, (i == 0) ? 3'd4 : 3'd1, 1'b1, 1'b0, 1'b0);
      if (i == 255) check_result("m4", 2'd0, 16'hFFC0);
      else          check($sformatf("m4_idle%0d", i), 32'(bus.out_valid), 32'd0);
    end
    step(1'b0, 2'd0, 10'h000, 3'd0, 1'b1, 1'b0, 1'b0);

    // Partial burst, then soft_clr coinciding with a fresh first sample.
    step(1'b1, 2'd0, 10'h3FF, 3'd1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 2'd0, 10'h3FF, 3'd1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 2'd0, 10'h100, 3'd1, 1'b1, (i == 0) ? 1'b1 : 1'b0, 1'b0);
      if (i == 3) check_result("sclr", 2'd0, 16'h4000);
      else        check($sformatf("sclr_idle%0d", i), 32'(bus.out_valid), 32'd0);
    end
    step(1'b0, 2'd0, 10'h000, 3'd0, 1'b1, 1'b0, 1'b0);

    // Partial burst, then asynchronous reset mid-burst.
    step(1'b1, 2'd0, 10'h3FF, 3'd1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 2'd0, 10'h3FF, 3'd1, 0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    check_reset_state("rst_mid");
    #2 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 2'd0, 10'h100, 3'd1, 1'b1, 1'b0, 1'b0);
      if (i == 3) check_result("rst", 2'd0, 16'h4000);
      else        check($sformatf("rst_idle%0d", i), 32'(bus.out_valid), 32'd0);
    end
    step(1'b0, 2'd0, 10'h000, 3'd0, 1'b1, 1'b0, 1'b0);
    check("final_pop", 32'(bus.out_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
